// File: rtl/freq_gen.sv
// freq_gen: programmable 50% duty square-wave source with on-block divider.
// Optional build macro FGEN_ROUND_EN selects round-to-nearest half period.
module freq_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int FW     = 20
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic [FW-1:0] freq,
  input  logic          load,
  output logic          busy,
  output logic          active,
  output logic          OUT
);

  localparam int DW = $clog2(CLK_HZ + 2**FW);
  localparam int IW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    APPLY
  } state_t;

  state_t state;
  state_t state_d;

  logic          accept;
  logic          stop;
  logic          last;

  logic [FW:0]   dvs_q;
  logic [DW-1:0] dvd_q;
  logic [FW:0]   rem_q;
  logic [DW-1:0] quo_q;
  logic [IW-1:0] it_q;

  logic [FW+1:0] rem_sh;
  logic [FW+1:0] dvs_ext;
  logic          ge;
  logic [FW:0]   rem_nx;
  logic [DW-1:0] dividend;
  logic [DW-1:0] res;

  logic [DW-1:0] cnt;
  logic [DW-1:0] half;
  logic [DW-1:0] pend_half;
  logic          pend;
  logic          wrap;

`ifdef FGEN_ROUND_EN
  assign dividend = DW'(CLK_HZ) + DW'(freq);
`else
  assign dividend = DW'(CLK_HZ);
`endif

  // FSM state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next state, load qualification and busy flag
  always_comb begin
    state_d = state;
    accept  = 1'b0;
    stop    = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE: begin
        busy   = 1'b0;
        accept = load && (freq != '0);
        stop   = load && (freq == '0);
        if (accept) begin
          state_d = DIV;
        end
      end
      DIV: begin
        if (last) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One restoring-division step: shift in next dividend bit, try subtract
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DW-1]};
    dvs_ext = {1'b0, dvs_q};
    ge      = (rem_sh >= dvs_ext);
    rem_nx  = ge ? (FW+1)'(rem_sh - dvs_ext)
                 : (FW+1)'(rem_sh);
    last    = (it_q == IW'(DW - 1));
  end

  // Quotient always fits DW bits because the dividend is below 2**DW,
  // so saturation never triggers; only the zero case needs clamping.
  always_comb begin
    res = quo_q;
    if (quo_q == '0) begin
      res = DW'(1);
    end
  end

  // Divider datapath: latch operands on accept, iterate MSB first in DIV
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      dvs_q <= '0;
      dvd_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      it_q  <= '0;
    end else if (accept) begin
      dvs_q <= {freq, 1'b0};
      dvd_q <= dividend;
      rem_q <= '0;
      quo_q <= '0;
      it_q  <= '0;
    end else if (state == DIV) begin
      dvd_q <= {dvd_q[DW-2:0], 1'b0};
      rem_q <= rem_nx;
      quo_q <= {quo_q[DW-2:0], ge};
      it_q  <= it_q + IW'(1);
    end
  end

  assign wrap = (cnt == half - DW'(1));

  // Generator: count, toggle, take pending half period on a toggle;
  // stop and apply override the free-running update
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      active    <= 1'b0;
      OUT       <= 1'b0;
      cnt       <= '0;
      half      <= '0;
      pend      <= 1'b0;
      pend_half <= '0;
    end else begin
      if (active) begin
        if (wrap) begin
          OUT <= ~OUT;
          cnt <= '0;
          if (pend) begin
            half <= pend_half;
            pend <= 1'b0;
          end
        end else begin
          cnt <= cnt + DW'(1);
        end
      end
      if (stop) begin
        active <= 1'b0;
        OUT    <= 1'b0;
        cnt    <= '0;
        pend   <= 1'b0;
      end else if (state == APPLY) begin
        if (!active) begin
          half   <= res;
          cnt    <= '0;
          OUT    <= 1'b0;
          active <= 1'b1;
        end else begin
          pend_half <= res;
          pend      <= 1'b1;
        end
      end
    end
  end

endmodule
